// File: rtl/mdio_peripheral.sv
`timescale 1ns/1ps
// MDIO responder: decodes frames sampled on MDC rising edges, holds a local
// 16-bit register bank and shifts read data back on MDIO_IN.
module mdio_peripheral #(
    parameter logic [4:0] PHY_ADDR = 5'd0,
    parameter int         NUM_REGS = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MDC,
    input  logic        MDIO_OUT,
    input  logic        MDIO_OE,
    output logic        MDIO_IN,
    output logic        MDIO_IN_OE,
    output logic        WR_STB,
    output logic [4:0]  WR_ADDR,
    output logic [15:0] WR_DATA,
    output logic        FRAME_ERR,
    output logic [2:0]  dbg_state_o
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HEADER  = 3'd1,
        WDATA   = 3'd2,
        RDATA   = 3'd3,
        DISCARD = 3'd4
    } state_t;

    localparam logic [5:0] NUM_REGS_W = 6'(NUM_REGS);

    state_t      state_q, state_d;
    logic        mdc_q;
    logic [31:0] shift_q, shift_d;
    logic [5:0]  bit_cnt_q, bit_cnt_d, cnt_inc;
    logic        idle_cnt_q, idle_cnt_d;
    logic [15:0] rd_sh_q, rd_sh_d;
    logic [15:0] bank_q [NUM_REGS];
    logic        wr_en_d, wr_stb_q;
    logic [4:0]  wr_addr_q;
    logic [15:0] wr_data_q;
    logic        ferr_d, ferr_q;
    logic        mdc_edge, sample;
    logic [4:0]  hdr_regad, wr_regad;
    logic [15:0] rd_word;

    assign mdc_edge  = MDC & ~mdc_q;
    assign sample    = mdc_edge & MDIO_OE;
    assign shift_d   = sample ? {shift_q[30:0], MDIO_OUT} : shift_q;
    assign cnt_inc   = (bit_cnt_q == 6'd32) ? 6'd32 : bit_cnt_q + 6'd1;
    // Field positions are taken from shift_d so decisions use the bit sampled this edge.
    assign hdr_regad = shift_d[6:2];
    assign wr_regad  = shift_d[22:18];

    always_comb begin
        rd_word = '0;
        if ({1'b0, hdr_regad} < NUM_REGS_W) begin
            rd_word = bank_q[hdr_regad];
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        idle_cnt_d = idle_cnt_q;
        rd_sh_d    = rd_sh_q;
        wr_en_d    = 1'b0;
        ferr_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (sample) begin
                    bit_cnt_d = 6'd1;
                    state_d   = HEADER;
                end
            end
            HEADER: begin
                if (mdc_edge) begin
                    if (!MDIO_OE) begin
                        ferr_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        bit_cnt_d = cnt_inc;
                        if (cnt_inc == 6'd4 && (shift_d[3:2] != 2'b01 ||
                            !(shift_d[1:0] == 2'b01 || shift_d[1:0] == 2'b10))) begin
                            ferr_d     = 1'b1;
                            idle_cnt_d = 1'b0;
                            state_d    = DISCARD;
                        end else if (cnt_inc == 6'd16) begin
                            if (shift_d[11:7] != PHY_ADDR) begin
                                idle_cnt_d = 1'b0;
                                state_d    = DISCARD;
                            end else if (shift_d[13:12] == 2'b01) begin
                                state_d = WDATA;
                            end else begin
                                rd_sh_d = rd_word;
                                state_d = RDATA;
                            end
                        end
                    end
                end
            end
            WDATA: begin
                if (mdc_edge) begin
                    if (!MDIO_OE) begin
                        ferr_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        bit_cnt_d = cnt_inc;
                        if (cnt_inc == 6'd32) begin
                            state_d = IDLE;
                            if (shift_d[17:16] == 2'b10) begin
                                wr_en_d = 1'b1;
                            end else begin
                                ferr_d = 1'b1;
                            end
                        end
                    end
                end
            end
            RDATA: begin
                // bit_cnt continues from 16, so reaching 32 marks the 16th data edge.
                if (mdc_edge) begin
                    bit_cnt_d = cnt_inc;
                    rd_sh_d   = {rd_sh_q[14:0], 1'b0};
                    if (cnt_inc == 6'd32) begin
                        state_d = IDLE;
                    end
                end
            end
            DISCARD: begin
                if (mdc_edge) begin
                    if (MDIO_OE) begin
                        idle_cnt_d = 1'b0;
                    end else if (idle_cnt_q) begin
                        state_d = IDLE;
                    end else begin
                        idle_cnt_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            mdc_q      <= 1'b0;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            idle_cnt_q <= 1'b0;
            rd_sh_q    <= '0;
            wr_stb_q   <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mdc_q      <= MDC;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            idle_cnt_q <= idle_cnt_d;
            rd_sh_q    <= rd_sh_d;
            wr_stb_q   <= wr_en_d;
            ferr_q     <= ferr_d;
            if (wr_en_d) begin
                wr_addr_q <= wr_regad;
                wr_data_q <= shift_d[15:0];
            end
        end
    end

    // WR_STB/WR_ADDR still report writes to unimplemented registers; only the bank skips them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                bank_q[i] <= '0;
            end
        end else if (wr_en_d && ({1'b0, wr_regad} < NUM_REGS_W)) begin
            bank_q[wr_regad] <= shift_d[15:0];
        end
    end

    assign MDIO_IN_OE  = (state_q == RDATA);
    assign MDIO_IN     = MDIO_IN_OE & rd_sh_q[15];
    assign WR_STB      = wr_stb_q;
    assign WR_ADDR     = wr_addr_q;
    assign WR_DATA     = wr_data_q;
    assign FRAME_ERR   = ferr_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mdio_peripheral.sv
`timescale 1ns/1ps
// Bench for mdio_peripheral: frames are driven bit by bit, a field-level model
// predicts each frame's outcome, and a monitor checks DUT events against it.
module tb_mdio_peripheral;

    localparam logic [4:0] TB_PHY  = 5'd1;
    localparam int         TB_REGS = 24;
    localparam int         HALF    = 3;
    localparam int         W       = 23;
    localparam logic [1:0] EV_WR   = 2'd1;
    localparam logic [1:0] EV_ERR  = 2'd2;
    localparam logic [1:0] EV_RD   = 2'd3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic mdc = 1'b0;
    logic mdio_out = 1'b0;
    logic mdio_oe = 1'b0;
    logic        mdio_in, mdio_in_oe, wr_stb, frame_err;
    logic [4:0]  wr_addr;
    logic [15:0] wr_data;
    logic [2:0]  dbg_state;

    // Each expected event: {kind, addr, data}; reads and errors carry addr 0.
    logic [W-1:0] exp_q[$];
    logic [15:0]  model_bank [32];
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mdio_peripheral #(.PHY_ADDR(TB_PHY), .NUM_REGS(TB_REGS)) dut (
        .clk        (clk),
        .reset      (rst_n),
        .MDC        (mdc),
        .MDIO_OUT   (mdio_out),
        .MDIO_OE    (mdio_oe),
        .MDIO_IN    (mdio_in),
        .MDIO_IN_OE (mdio_in_oe),
        .WR_STB     (wr_stb),
        .WR_ADDR    (wr_addr),
        .WR_DATA    (wr_data),
        .FRAME_ERR  (frame_err),
        .dbg_state_o(dbg_state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pop_check(input string name, input logic [W-1:0] act);
        logic [W-1:0] e;
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: got unexpected event %h expected no event", name, act);
        end else begin
            e = exp_q.pop_front();
            check(name, 32'(act), 32'(e));
        end
    endtask

    // Monitor: samples #1 after each clk edge; serial read bits are the values
    // held just before each MDC rising edge.
    logic        prev_mdc = 1'b0;
    logic        prev_in = 1'b0;
    logic        prev_oe = 1'b0;
    int          rd_bits = 0;
    logic [15:0] rd_acc = '0;

    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            rd_bits = 0;
        end else begin
            if (wr_stb)    pop_check("write", {EV_WR, wr_addr, wr_data});
            if (frame_err) pop_check("frame_err", {EV_ERR, 5'd0, 16'd0});
            if (mdc && !prev_mdc && prev_oe) begin
                rd_acc = {rd_acc[14:0], prev_in};
                rd_bits++;
                if (rd_bits == 16) begin
                    pop_check("read", {EV_RD, 5'd0, rd_acc});
                    rd_bits = 0;
                end
            end
        end
        prev_mdc = mdc;
        prev_in  = mdio_in;
        prev_oe  = mdio_in_oe;
    end

    task automatic mdc_cycle(input logic oe, input logic val);
        mdc      = 1'b0;
        mdio_oe  = oe;
        mdio_out = val;
        repeat (HALF) @(negedge clk);
        mdc = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) mdc_cycle(1'b0, 1'b0);
    endtask

    function automatic logic [31:0] mk_frame(input logic [1:0] st, input logic [1:0] op,
                                             input logic [4:0] phy, input logic [4:0] rg,
                                             input logic [1:0] ta, input logic [15:0] data);
        return {st, op, phy, rg, ta, data};
    endfunction

    // A reading controller releases the bus for the data half of the frame.
    task automatic drive_frame(input logic [31:0] frame, input bit is_read,
                               input int abort_k, input int nbits);
        logic oe;
        for (int i = 1; i <= nbits; i++) begin
            oe = (i < abort_k) && !(is_read && i > 16);
            mdc_cycle(oe, oe ? frame[32-i] : 1'b0);
        end
    endtask

    // Reference model: outcome of a frame from its fields and the bit at which
    // the controller drops MDIO_OE (33 = never).
    task automatic predict(input logic [1:0] st, input logic [1:0] op, input logic [4:0] phy,
                           input logic [4:0] rg, input logic [1:0] ta, input logic [15:0] data,
                           input int abort_k);
        logic [15:0] rv;
        if (abort_k <= 4) begin
            exp_q.push_back({EV_ERR, 5'd0, 16'd0});
        end else if (st != 2'b01 || !(op == 2'b01 || op == 2'b10)) begin
            exp_q.push_back({EV_ERR, 5'd0, 16'd0});
        end else if (abort_k <= 16) begin
            exp_q.push_back({EV_ERR, 5'd0, 16'd0});
        end else if (phy != TB_PHY) begin
            // another PHY's frame: silently ignored
        end else if (op == 2'b10) begin
            rv = (int'(rg) < TB_REGS) ? model_bank[rg] : 16'h0000;
            exp_q.push_back({EV_RD, 5'd0, rv});
        end else if (abort_k <= 32) begin
            exp_q.push_back({EV_ERR, 5'd0, 16'd0});
        end else if (ta != 2'b10) begin
            exp_q.push_back({EV_ERR, 5'd0, 16'd0});
        end else begin
            exp_q.push_back({EV_WR, rg, data});
            if (int'(rg) < TB_REGS) model_bank[rg] = data;
        end
    endtask

    task automatic do_frame(input logic [1:0] st, input logic [1:0] op, input logic [4:0] phy,
                            input logic [4:0] rg, input logic [1:0] ta, input logic [15:0] data,
                            input int abort_k);
        predict(st, op, phy, rg, ta, data, abort_k);
        drive_frame(mk_frame(st, op, phy, rg, ta, data), op == 2'b10, abort_k, 32);
        idle(3);
    endtask

    task automatic wr(input logic [4:0] rg, input logic [15:0] data);
        do_frame(2'b01, 2'b01, TB_PHY, rg, 2'b10, data, 33);
    endtask

    task automatic rd(input logic [4:0] rg);
        do_frame(2'b01, 2'b10, TB_PHY, rg, 2'b10, 16'h0000, 33);
    endtask

    task automatic reset_mid(input string tag);
        mdc      = 1'b0;
        mdio_oe  = 1'b0;
        mdio_out = 1'b0;
        rst_n    = 1'b0;
        #1;
        check({tag, "_flags"}, {28'd0, mdio_in_oe, mdio_in, wr_stb, frame_err}, 32'd0);
        check({tag, "_wr_regs"}, {11'd0, wr_addr, wr_data}, 32'd0);
        for (int i = 0; i < 32; i++) model_bank[i] = 16'h0000;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        idle(3);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

    initial begin
        logic [1:0]  st, op, ta;
        logic [4:0]  phy, rg;
        logic [15:0] data;
        int          ab;

        for (int i = 0; i < 32; i++) model_bank[i] = 16'h0000;
        repeat (5) @(negedge clk);
        check("reset_flags", {28'd0, mdio_in_oe, mdio_in, wr_stb, frame_err}, 32'd0);
        check("reset_wr_regs", {11'd0, wr_addr, wr_data}, 32'd0);
        rst_n = 1'b1;
        idle(2);

        // Write then read back, foreign PHY, bad ST, bad TA, bad OP, abort.
        wr(5'd3, 16'hBEEF);
        rd(5'd3);
        do_frame(2'b01, 2'b01, 5'd0, 5'd3, 2'b10, 16'h1234, 33);
        do_frame(2'b01, 2'b10, 5'd0, 5'd3, 2'b10, 16'h0000, 33);
        rd(5'd3);
        do_frame(2'b11, 2'b01, TB_PHY, 5'd3, 2'b10, 16'h7777, 33);
        wr(5'd1, 16'hAAAA);
        rd(5'd1);
        do_frame(2'b01, 2'b01, TB_PHY, 5'd3, 2'b00, 16'h5555, 33);
        rd(5'd3);
        do_frame(2'b01, 2'b00, TB_PHY, 5'd3, 2'b10, 16'h0101, 33);
        do_frame(2'b01, 2'b11, TB_PHY, 5'd3, 2'b10, 16'h0202, 33);
        do_frame(2'b01, 2'b01, TB_PHY, 5'd3, 2'b10, 16'h0303, 10);
        do_frame(2'b01, 2'b01, TB_PHY, 5'd3, 2'b10, 16'h0404, 25);
        rd(5'd3);

        // Last implemented register versus the first unimplemented ones.
        wr(5'd23, 16'h1357);
        rd(5'd23);
        wr(5'd24, 16'h2468);
        rd(5'd24);
        rd(5'd31);

        // Reset 20 bits into a write: nothing is written, bank is cleared.
        drive_frame(mk_frame(2'b01, 2'b01, TB_PHY, 5'd3, 2'b10, 16'h1111), 1'b0, 33, 20);
        reset_mid("rst_in_write");
        rd(5'd3);
        wr(5'd3, 16'h4242);
        rd(5'd3);

        // Reset while read data is being shifted out.
        drive_frame(mk_frame(2'b01, 2'b10, TB_PHY, 5'd3, 2'b10, 16'h0000), 1'b1, 33, 21);
        check("read_oe_active", {31'd0, mdio_in_oe}, 32'd1);
        reset_mid("rst_in_read");
        rd(5'd3);

        for (int n = 0; n < 100; n++) begin
            st   = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 3)) : 2'b01;
            op   = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 3))
                 : (($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10);
            phy  = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(0, 31)) : TB_PHY;
            rg   = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            ta   = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 3)) : 2'b10;
            data = 16'($urandom);
            ab   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(2, 32)) : 33;
            do_frame(st, op, phy, rg, ta, data, ab);
        end

        idle(4);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("no_partial_read", 32'(rd_bits), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mdio_peripheral.md
Name: mdio_peripheral

Overview:
- Responder (PHY side) of the Clause-22-style MDIO management link; mates with the team's MDIO controller on the same clk.
- Decodes frames from MDC/MDIO_OUT/MDIO_OE and holds a local 16-bit register bank.
- Writes update the bank; reads are answered by shifting 16 data bits back on MDIO_IN.
- Sits beside the controller in the top-level and in the integration bench.

Parameters:
- PHY_ADDR, 5'd0, PHYAD this block responds to; frames with any other PHYAD are ignored.
- NUM_REGS, 32, number of implemented 16-bit registers (1..32); REGAD >= NUM_REGS is unimplemented.

Ports:
- clk  input  1  system clock, same clock as the MDIO controller.
- reset  input  1  asynchronous, active-low reset.
- MDC  input  1  management clock from the controller.
- MDIO_OUT  input  1  serial data from the controller.
- MDIO_OE  input  1  controller drive enable; high = MDIO_OUT is valid.
- MDIO_IN  output  1  serial read data to the controller.
- MDIO_IN_OE  output  1  high while this block drives MDIO_IN.
- WR_STB  output  1  one-clk pulse when a register is written.
- WR_ADDR  output  5  REGAD of the last write.
- WR_DATA  output  16  data of the last write.
- FRAME_ERR  output  1  one-clk pulse on a rejected or aborted frame.

Behaviour:
- Reset: all outputs 0, bank all 0x0000, state IDLE, edge register and counters 0. Reset is asynchronous, takes effect mid-frame, and suppresses any pending write.
- MDC rising edge: registered MDC_d; an edge is (MDC_d==0 && MDC==1) in the current clk. All sampling and shifting happen only on edge cycles.
- Sampling: on an edge cycle with MDIO_OE==1, shift MDIO_OUT into a 32-bit shift register, MSB first. The first sampled bit is ST[1].
- IDLE: on the first edge with MDIO_OE==1, capture the bit, set bit_cnt=1, go to HEADER.
- HEADER: collect 16 bits (ST, OP, PHYAD, REGAD, TA).
  - At bit 4: if ST!=2'b01 or OP is not in {01, 10}, pulse FRAME_ERR and go to DISCARD.
  - At bit 16: if PHYAD!=PHY_ADDR, go to DISCARD (no error).
  - Otherwise OP=01 goes to WDATA; OP=10 goes to RDATA.
- WDATA: collect 16 more bits. At bit 32, check TA==2'b10.
  - On pass: in the next clk, write the bank if REGAD<NUM_REGS, pulse WR_STB, and update WR_ADDR/WR_DATA, even for an unimplemented REGAD.
  - On TA fail: pulse FRAME_ERR, no write.
  - Either way, return to IDLE.
- RDATA: load bank[REGAD] (0x0000 if unimplemented) into a 16-bit output shifter.
  - In the clk after entering RDATA: MDIO_IN_OE=1, MDIO_IN=bit15.
  - Each later MDC edge shifts to the next bit.
  - After bit0 has been presented for one full MDC period, at the 16th edge: MDIO_IN_OE=0, MDIO_IN=0, go to IDLE.
  - Read TA bits are don't-care.
  - MDIO_OE is ignored in RDATA.
- DISCARD: ignore edges until MDIO_OE has been 0 for 2 consecutive edges, then go to IDLE. The block never drives the bus in DISCARD.
- Abort: MDIO_OE==0 on an edge during HEADER or WDATA means pulse FRAME_ERR, no write, go to IDLE.
- Simultaneous events: a WR_STB pulse and a new IDLE→HEADER capture in the same clk are both honoured. A frame start coinciding with the end of RDATA is missed; the controller must idle at least one MDC period between frames.
- Widths: bit_cnt is 6 bits and saturates at 32; bank indexing uses REGAD[4:0] directly.

Test Plan:
- Write: controller T_DATA=0x500EBEEF, PHY_ADDR=0 -> WR_STB pulses once, WR_ADDR=3, WR_DATA=0xBEEF, bank[3]=0xBEEF, FRAME_ERR stays 0.
- Read-back: after the write, T_DATA=0x600C0000 -> MDIO_IN_OE high for 16 MDC periods, serial 0xBEEF MSB first, controller DATA_RDY asserts.
- Address mismatch: PHY_ADDR=1, T_DATA=0x500E1234 -> no WR_STB, no FRAME_ERR, bank[3] unchanged, MDIO_IN_OE stays 0.
- Bad ST: first bits 2'b11 -> FRAME_ERR pulse at bit 4, DISCARD, no write. A following valid frame (0x5006AAAA) writes bank[1]=0xAAAA.
- Bad TA: write with TA=2'b00 (0x500CBEEF) -> FRAME_ERR pulse, no WR_STB, bank[3] unchanged.
- Reset mid-frame: assert reset after 20 bits of 0x500E1111 -> all outputs 0 immediately, bank[3]=0. After release, the next valid write succeeds.
